level_sequencer: RTL and testbench
==================================

Name: level_sequencer

Overview:
- Game controller that runs the three-level subsystem-survival sequence (L1 -> L2 -> L3) from a single owned 5-bit LFSR.
- Per level: draws a random subsystem vector, checks the crucial subsystems and opens a timed window in which the player switches off faulty switchable subsystems.
- Reports pass, fail, win and score.
- Replaces the per-level free-running LFSR instances with one sequenced source and one FSM.

Parameters:
TIMEOUT, 100, switch-window length in cycles (1..2^TW-1)
TW, 8, timer width

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
start  in  1  begin game; sampled in IDLE, FAIL or WIN
next  in  1  advance to the next level; sampled in PASS
seed_we  in  1  load seed into the LFSR this cycle
seed  in  5  LFSR load value
sw  in  5  player switch-off requests; only bits [3:2] are meaningful
level  out  2  current level, 1..3; 0 in IDLE
r_vec  out  5  drawn subsystem vector; bit i=1 means subsystem i works
o_vec  out  5  r_vec & ~off_mask, the effective subsystem outputs
pending  out  5  faulty switchable bits not yet switched off
level_pass  out  1  one-cycle pulse on entry to PASS
game_over  out  1  sticky in FAIL
game_won  out  1  sticky in WIN
score  out  3  sum of passed level numbers, 0..6
timer  out  TW  remaining window cycles

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, lfsr=00001, all outputs 0, off_mask=0.
- LFSR:
  - Free-runs every cycle: lfsr <= {lfsr[3:0], lfsr[4]^lfsr[2]}.
  - seed_we has priority and loads seed; a seed of 00000 loads 00001 instead.
- Level masks (crucial/switchable):
  - L1: 01111/00000
  - L2: 00111/01000
  - L3: 00011/01100
  - Bit 4 is never crucial.
- IDLE, FAIL or WIN with start=1: level<=1, score<=0, clear game_over and game_won -> DRAW.
- DRAW (1 cycle): r_vec<=lfsr, off_mask<=0 -> EVAL.
  - seed_we together with start/next therefore makes the draw equal seed exactly.
- EVAL (1 cycle):
  - Any crucial bit 0 -> FAIL.
  - Otherwise pending<=switchable&~r_vec. If pending is nonzero, timer<=TIMEOUT -> WAIT_SW.
  - Otherwise score<=score+level -> PASS.
- WAIT_SW, evaluated per cycle:
  - Any sw bit that is switchable and working (r_vec=1) -> FAIL immediately; this takes priority.
  - Bits with sw&pending clear from pending and set in off_mask.
  - If pending becomes 0 this cycle -> score+=level, PASS. This wins over timeout when both happen in the same cycle.
  - Else if timer==1 -> FAIL. Otherwise timer decrements.
  - sw on non-switchable bits is ignored.
- PASS:
  - level_pass=1 on the first cycle only.
  - If level==3 -> WIN.
  - Otherwise wait for next=1: level+=1 -> DRAW.
- FAIL and WIN hold all outputs until start.
- start in any other state is ignored; next outside PASS is ignored.
- rst is asserted mid-operation -> immediate return to reset values.
- Latency: start edge k -> r_vec valid cycle k+2 -> verdict (state change) at edge k+2.

Decomposition:
- Package lvl_pkg holds:
  - state enum (IDLE, DRAW, EVAL, WAIT_SW, PASS, FAIL, WIN)
  - CRUCIAL_MASK[1..3] and SWITCH_MASK[1..3] constants
  - LFSR_SEED=00001
- One sub-module: seq_lfsr5, the 5-bit XOR LFSR with synchronous load, zero-seed remap and async active-low reset.

Test Plan:
1. start+seed_we seed=00111 -> r_vec=00111 at k+2, then game_over=1, level=1, score=0.
2. start+seed=01111 -> level_pass pulse, score=1. Then next+seed=10111 -> pending=01000; sw=01000 after 5 cycles -> PASS, o_vec=10111, score=3.
3. Continue from test 2: next+seed=00011 -> pending=01100; sw=00100 then sw=01000 -> PASS, game_won=1, score=6, o_vec=00011&~01100=00011.
4. L2 seed=10111 with sw=0 -> game_over asserted exactly TIMEOUT cycles after WAIT_SW entry, score=1. Repeat with sw[3] on the last cycle -> PASS.
5. L3 seed=00111 (bit2 working, bit3 faulty) with sw=00100 -> FAIL next edge; L1 sw activity ignored.
6. rst=0 asynchronously during WAIT_SW -> all outputs 0, IDLE. seed_we seed=00000 + start -> r_vec=00001 -> FAIL.

Source files
------------

// File: rtl/lvl_pkg.sv
// Shared types and constants for the three-level survival sequencer.
// Level masks, LFSR reset value and FSM state encoding.
package lvl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRAW,
        EVAL,
        WAIT_SW,
        PASS,
        FAIL,
        WIN
    } state_t;

    localparam logic [4:0] LFSR_SEED = 5'b00001;

    localparam logic [4:0] CRUCIAL_MASK [1:3] = '{
        5'b01111,
        5'b00111,
        5'b00011
    };

    localparam logic [4:0] SWITCH_MASK [1:3] = '{
        5'b00000,
        5'b01000,
        5'b01100
    };

    function automatic logic [4:0] crucial_of(input logic [1:0] lvl);
        logic [4:0] m;
        m = 5'b00000;
        case (lvl)
            2'd1:    m = CRUCIAL_MASK[1];
            2'd2:    m = CRUCIAL_MASK[2];
            2'd3:    m = CRUCIAL_MASK[3];
            default: m = 5'b00000;
        endcase
        return m;
    endfunction

    function automatic logic [4:0] switch_of(input logic [1:0] lvl);
        logic [4:0] m;
        m = 5'b00000;
        case (lvl)
            2'd1:    m = SWITCH_MASK[1];
            2'd2:    m = SWITCH_MASK[2];
            2'd3:    m = SWITCH_MASK[3];
            default: m = 5'b00000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/seq_lfsr5.sv
// 5-bit XOR LFSR, the single random source for all levels.
// Synchronous load has priority; an all-zero seed is remapped.
module seq_lfsr5
    import lvl_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic [4:0] i_seed,
    output logic [4:0] o_q
);

    logic [4:0] r_q;

    // Load the seed when asked, otherwise shift with feedback 4^2.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= LFSR_SEED;
        end else if (i_load) begin
            r_q <= (i_seed == 5'b00000) ? LFSR_SEED : i_seed;
        end else begin
            r_q <= {r_q[3:0], r_q[4] ^ r_q[2]};
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/level_sequencer.sv
// Three-level subsystem-survival game controller.
// One LFSR draws each level's vector; one FSM runs the levels.
module level_sequencer
    import lvl_pkg::*;
#(
    parameter int TIMEOUT = 100,
    parameter int TW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          next,
    input  logic          seed_we,
    input  logic [4:0]    seed,
    input  logic [4:0]    sw,
    output logic [1:0]    level,
    output logic [4:0]    r_vec,
    output logic [4:0]    o_vec,
    output logic [4:0]    pending,
    output logic          level_pass,
    output logic          game_over,
    output logic          game_won,
    output logic [2:0]    score,
    output logic [TW-1:0] timer
);

    localparam logic [TW-1:0] LP_TIMEOUT = TW'(TIMEOUT);
    localparam logic [TW-1:0] LP_ONE     = TW'(1);

    state_t        r_state;
    state_t        w_state_n;
    logic [1:0]    r_lvl,   w_lvl_n;
    logic [4:0]    r_draw,  w_draw_n;
    logic [4:0]    r_off,   w_off_n;
    logic [4:0]    r_pend,  w_pend_n;
    logic          r_pass,  w_pass_n;
    logic          r_over,  w_over_n;
    logic          r_won,   w_won_n;
    logic [2:0]    r_score, w_score_n;
    logic [TW-1:0] r_timer, w_timer_n;

    logic [4:0]    w_lfsr;
    logic [4:0]    w_crit;
    logic [4:0]    w_swm;
    logic [4:0]    w_bad;
    logic [4:0]    w_hit;
    logic [4:0]    w_rem;
    logic [4:0]    w_fault;
    logic [2:0]    w_score_add;

    seq_lfsr5 u_lfsr (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_load  (seed_we),
        .i_seed  (seed),
        .o_q     (w_lfsr)
    );

    assign w_crit      = crucial_of(r_lvl);
    assign w_swm       = switch_of(r_lvl);
    assign w_bad       = sw & w_swm & r_draw;
    assign w_hit       = sw & r_pend;
    assign w_rem       = r_pend & ~sw;
    assign w_fault     = w_swm & ~r_draw;
    assign w_score_add = r_score + {1'b0, r_lvl};

    // Register FSM state and all datapath state together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_lvl   <= 2'd0;
            r_draw  <= 5'b00000;
            r_off   <= 5'b00000;
            r_pend  <= 5'b00000;
            r_pass  <= 1'b0;
            r_over  <= 1'b0;
            r_won   <= 1'b0;
            r_score <= 3'd0;
            r_timer <= '0;
        end else begin
            r_state <= w_state_n;
            r_lvl   <= w_lvl_n;
            r_draw  <= w_draw_n;
            r_off   <= w_off_n;
            r_pend  <= w_pend_n;
            r_pass  <= w_pass_n;
            r_over  <= w_over_n;
            r_won   <= w_won_n;
            r_score <= w_score_n;
            r_timer <= w_timer_n;
        end
    end

    // Next-state and datapath updates for each game phase.
    always_comb begin
        w_state_n = r_state;
        w_lvl_n   = r_lvl;
        w_draw_n  = r_draw;
        w_off_n   = r_off;
        w_pend_n  = r_pend;
        w_pass_n  = 1'b0;
        w_over_n  = r_over;
        w_won_n   = r_won;
        w_score_n = r_score;
        w_timer_n = r_timer;
        unique case (r_state)
            IDLE, FAIL, WIN: begin
                if (start) begin
                    w_lvl_n   = 2'd1;
                    w_score_n = 3'd0;
                    w_over_n  = 1'b0;
                    w_won_n   = 1'b0;
                    w_state_n = DRAW;
                end
            end
            DRAW: begin
                w_draw_n  = w_lfsr;
                w_off_n   = 5'b00000;
                w_state_n = EVAL;
            end
            EVAL: begin
                if ((r_draw & w_crit) != w_crit) begin
                    w_over_n  = 1'b1;
                    w_state_n = FAIL;
                end else begin
                    w_pend_n = w_fault;
                    if (w_fault != 5'b00000) begin
                        w_timer_n = LP_TIMEOUT;
                        w_state_n = WAIT_SW;
                    end else begin
                        w_score_n = w_score_add;
                        w_pass_n  = 1'b1;
                        w_state_n = PASS;
                    end
                end
            end
            WAIT_SW: begin
                if (w_bad != 5'b00000) begin
                    w_over_n  = 1'b1;
                    w_state_n = FAIL;
                end else begin
                    w_pend_n = w_rem;
                    w_off_n  = r_off | w_hit;
                    if (w_rem == 5'b00000) begin
                        w_score_n = w_score_add;
                        w_pass_n  = 1'b1;
                        w_state_n = PASS;
                    end else if (r_timer == LP_ONE) begin
                        w_over_n  = 1'b1;
                        w_state_n = FAIL;
                    end else begin
                        w_timer_n = r_timer - LP_ONE;
                    end
                end
            end
            PASS: begin
                if (r_lvl == 2'd3) begin
                    w_won_n   = 1'b1;
                    w_state_n = WIN;
                end else if (next) begin
                    w_lvl_n   = r_lvl + 2'd1;
                    w_state_n = DRAW;
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    assign level      = r_lvl;
    assign r_vec      = r_draw;
    assign o_vec      = r_draw & ~r_off;
    assign pending    = r_pend;
    assign level_pass = r_pass;
    assign game_over  = r_over;
    assign game_won   = r_won;
    assign score      = r_score;
    assign timer      = r_timer;

endmodule

// File: tb/tb_level_sequencer.sv
// Self-checking bench for level_sequencer.
// Directed scenarios plus random games against a level-outcome model.
module tb_level_sequencer;

    localparam int TO  = 100;
    localparam int TWB = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           next;
    logic           seed_we;
    logic [4:0]     seed;
    logic [4:0]     sw;
    logic [1:0]     level;
    logic [4:0]     r_vec;
    logic [4:0]     o_vec;
    logic [4:0]     pending;
    logic           level_pass;
    logic           game_over;
    logic           game_won;
    logic [2:0]     score;
    logic [TWB-1:0] timer;

    int checks   = 0;
    int failures = 0;
    int exp_score;
    int m_lfsr;
    logic [4:0] sw_idle;

    logic [4:0] crit_t [0:3];
    logic [4:0] swm_t  [0:3];

    always #5 clk = ~clk;

    level_sequencer #(.TIMEOUT(TO), .TW(TWB)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .next       (next),
        .seed_we    (seed_we),
        .seed       (seed),
        .sw         (sw),
        .level      (level),
        .r_vec      (r_vec),
        .o_vec      (o_vec),
        .pending    (pending),
        .level_pass (level_pass),
        .game_over  (game_over),
        .game_won   (game_won),
        .score      (score),
        .timer      (timer)
    );

    // Arithmetic model of the random source: shift left, feed back bit4^bit2.
    always @(posedge clk or negedge rst) begin
        if (!rst)
            m_lfsr <= 1;
        else if (seed_we)
            m_lfsr <= (seed == 5'd0) ? 1 : int'(seed);
        else
            m_lfsr <= ((m_lfsr * 2) % 32) + (((m_lfsr / 16) + (m_lfsr / 4)) % 2);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        start = 1'b0; next = 1'b0; seed_we = 1'b0;
        seed = 5'd0; sw = 5'd0; sw_idle = 5'd0;
        exp_score = 0;
        tick;
        tick;
        rst = 1'b1;
        tick;
    endtask

    // Plays one level; modes: 0 fix faults randomly, 1 random noise,
    // 2 idle, 3 fix one fault per cycle from cycle 'at', 4 swv at 'at'.
    task automatic run_level(input bit is_start, input int lv,
                             input logic [4:0] s, input int mode,
                             input int at, input logic [4:0] swv,
                             output bit passed);
        logic [4:0] v, crit, swm, rem, offm, swt;
        v = (s == 5'd0) ? 5'd1 : s;
        crit = crit_t[lv];
        swm = swm_t[lv];
        passed = 1'b0;
        if (is_start) exp_score = 0;
        sw = sw_idle;
        start = is_start; next = !is_start;
        seed_we = 1'b1; seed = s;
        tick;
        start = 1'b0; next = 1'b0; seed_we = 1'b0;
        tick;
        checks++;
        if (r_vec !== v) begin
            failures++;
            $display("FAIL draw: r_vec=%b expected %b", r_vec, v);
        end
        checks++;
        if (level !== 2'(lv) || o_vec !== v) begin
            failures++;
            $display("FAIL draw_level: level=%0d o_vec=%b expected %0d %b",
                     level, o_vec, lv, v);
        end
        tick;
        sw = 5'd0;
        if ((v & crit) != crit) begin
            checks++;
            if (game_over !== 1'b1 || score !== 3'(exp_score) ||
                level !== 2'(lv)) begin
                failures++;
                $display("FAIL crucial: over=%b score=%0d level=%0d expected 1 %0d %0d",
                         game_over, score, level, exp_score, lv);
            end
            return;
        end
        rem = swm & ~v;
        if (rem == 5'd0) begin
            exp_score += lv;
            checks++;
            if (level_pass !== 1'b1 || score !== 3'(exp_score) ||
                game_over !== 1'b0) begin
                failures++;
                $display("FAIL direct_pass: pass=%b score=%0d over=%b expected 1 %0d 0",
                         level_pass, score, game_over, exp_score);
            end
            passed = 1'b1;
            return;
        end
        checks++;
        if (pending !== rem || timer !== 8'(TO) || game_over !== 1'b0) begin
            failures++;
            $display("FAIL window_open: pending=%b timer=%0d over=%b expected %b %0d 0",
                     pending, timer, game_over, rem, TO);
        end
        offm = 5'd0;
        for (int t = 1; t <= TO; t++) begin
            case (mode)
                0: swt = ($urandom_range(0, 5) == 0) ? (rem & 5'($urandom)) : 5'd0;
                1: swt = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'd0;
                3: swt = (t >= at) ? (rem & (~rem + 5'd1)) : 5'd0;
                4: swt = (t == at) ? swv : 5'd0;
                default: swt = 5'd0;
            endcase
            sw = swt;
            tick;
            sw = 5'd0;
            if ((swt & swm & v) != 5'd0) begin
                checks++;
                if (game_over !== 1'b1 || level_pass !== 1'b0 ||
                    score !== 3'(exp_score)) begin
                    failures++;
                    $display("FAIL bad_switch: over=%b pass=%b score=%0d expected 1 0 %0d",
                             game_over, level_pass, score, exp_score);
                end
                return;
            end
            offm |= swt & rem;
            rem &= ~swt;
            if (rem == 5'd0) begin
                exp_score += lv;
                checks++;
                if (level_pass !== 1'b1 || score !== 3'(exp_score) ||
                    pending !== 5'd0 || o_vec !== (v & ~offm)) begin
                    failures++;
                    $display("FAIL window_pass: pass=%b score=%0d pend=%b o_vec=%b expected 1 %0d 0 %b",
                             level_pass, score, pending, o_vec, exp_score, v & ~offm);
                end
                passed = 1'b1;
                return;
            end
            if (t == TO) begin
                checks++;
                if (game_over !== 1'b1 || score !== 3'(exp_score)) begin
                    failures++;
                    $display("FAIL timeout: over=%b score=%0d expected 1 %0d",
                             game_over, score, exp_score);
                end
                return;
            end
            checks++;
            if (pending !== rem || timer !== 8'(TO - t) || game_over !== 1'b0) begin
                failures++;
                $display("FAIL window_step t=%0d: pending=%b timer=%0d over=%b expected %b %0d 0",
                         t, pending, timer, game_over, rem, TO - t);
            end
        end
    endtask

    // Leave PASS towards the next level: pulse must already be gone.
    task automatic after_pass(input int lv);
        tick;
        checks++;
        if (lv == 3) begin
            if (game_won !== 1'b1 || level_pass !== 1'b0 ||
                score !== 3'(exp_score)) begin
                failures++;
                $display("FAIL win: won=%b pass=%b score=%0d expected 1 0 %0d",
                         game_won, level_pass, score, exp_score);
            end
        end else if (level_pass !== 1'b0 || game_won !== 1'b0) begin
            failures++;
            $display("FAIL pass_pulse: pass=%b won=%b expected 0 0",
                     level_pass, game_won);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        start = 1'b0; next = 1'b0; seed_we = 1'b0;
        seed = 5'd0; sw = 5'd0; sw_idle = 5'd0;
        #2;
        checks++;
        if ({level, r_vec, o_vec, pending, level_pass, game_over,
             game_won, score, timer} !== 31'd0) begin
            failures++;
            $display("FAIL reset_outputs: level=%0d r_vec=%b score=%0d timer=%0d expected all 0",
                     level, r_vec, score, timer);
        end
        tick;
        rst = 1'b1;
        next = 1'b1;
        tick;
        tick;
        next = 1'b0;
        checks++;
        if (level !== 2'd0 || game_over !== 1'b0) begin
            failures++;
            $display("FAIL idle_next: level=%0d over=%b expected 0 0", level, game_over);
        end
    endtask

    task automatic test_lfsr_free;
        int exp;
        do_reset;
        repeat ($urandom_range(3, 20)) tick;
        start = 1'b1;
        tick;
        exp = m_lfsr;
        start = 1'b0;
        tick;
        checks++;
        if (r_vec !== 5'(exp)) begin
            failures++;
            $display("FAIL lfsr_free: r_vec=%b expected %b", r_vec, 5'(exp));
        end
        do_reset;
    endtask

    task automatic test_crucial_fail;
        bit p;
        run_level(1'b1, 1, 5'b00111, 2, 0, 5'd0, p);
        next = 1'b1;
        tick;
        tick;
        next = 1'b0;
        checks++;
        if (game_over !== 1'b1 || level !== 2'd1 || score !== 3'd0 ||
            r_vec !== 5'b00111) begin
            failures++;
            $display("FAIL fail_hold: over=%b level=%0d score=%0d r_vec=%b expected 1 1 0 00111",
                     game_over, level, score, r_vec);
        end
    endtask

    task automatic test_full_game;
        bit p;
        run_level(1'b1, 1, 5'b01111, 2, 0, 5'd0, p);
        after_pass(1);
        run_level(1'b0, 2, 5'b10111, 3, 5, 5'd0, p);
        after_pass(2);
        run_level(1'b0, 3, 5'b00011, 3, 1, 5'd0, p);
        after_pass(3);
    endtask

    task automatic test_timeout;
        bit p;
        run_level(1'b1, 1, 5'b01111, 2, 0, 5'd0, p);
        after_pass(1);
        run_level(1'b0, 2, 5'b10111, 2, 0, 5'd0, p);
        run_level(1'b1, 1, 5'b11111, 2, 0, 5'd0, p);
        after_pass(1);
        run_level(1'b0, 2, 5'b10111, 3, TO, 5'd0, p);
        after_pass(2);
        run_level(1'b0, 3, 5'b10011, 4, 1, 5'b10011, p);
    endtask

    task automatic test_bad_switch;
        bit p;
        sw_idle = 5'b11111;
        run_level(1'b1, 1, 5'b01111, 2, 0, 5'd0, p);
        sw_idle = 5'd0;
        after_pass(1);
        run_level(1'b0, 2, 5'b10111, 3, 1, 5'd0, p);
        after_pass(2);
        run_level(1'b0, 3, 5'b00111, 4, 1, 5'b00100, p);
    endtask

    task automatic test_async_reset;
        bit p;
        run_level(1'b1, 1, 5'b01111, 2, 0, 5'd0, p);
        after_pass(1);
        next = 1'b1; seed_we = 1'b1; seed = 5'b10111;
        tick;
        next = 1'b0; seed_we = 1'b0;
        repeat (5) tick;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({level, r_vec, o_vec, pending, level_pass, game_over,
             game_won, score, timer} !== 31'd0) begin
            failures++;
            $display("FAIL async_reset: level=%0d pend=%b score=%0d timer=%0d expected all 0",
                     level, pending, score, timer);
        end
        tick;
        rst = 1'b1;
        tick;
        run_level(1'b1, 1, 5'b00000, 2, 0, 5'd0, p);
    endtask

    task automatic test_random_games;
        bit p;
        int lv, mode;
        logic [4:0] s;
        do_reset;
        for (int g = 0; g < 40; g++) begin
            lv = 1;
            p = 1'b1;
            while (p) begin
                s = ($urandom_range(0, 4) == 0) ? 5'($urandom)
                                                : (crit_t[lv] | 5'($urandom));
                mode = ($urandom_range(0, 9) == 0) ? 2 : int'($urandom_range(0, 1));
                run_level(lv == 1, lv, s, mode, 0, 5'd0, p);
                if (p) begin
                    after_pass(lv);
                    if (lv == 3) p = 1'b0;
                    lv++;
                end
            end
        end
    endtask

    initial begin
        crit_t[0] = 5'b00000; crit_t[1] = 5'b01111;
        crit_t[2] = 5'b00111; crit_t[3] = 5'b00011;
        swm_t[0]  = 5'b00000; swm_t[1]  = 5'b00000;
        swm_t[2]  = 5'b01000; swm_t[3]  = 5'b01100;
        test_reset;
        test_lfsr_free;
        test_crucial_fail;
        test_full_game;
        test_timeout;
        test_bad_switch;
        test_async_reset;
        test_random_games;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
